// File: rtl/tilelink_pkg.sv
// TileLink-UL channel bundles shared by the arbiter and its neighbours.
// A and D channel beats are carried as packed structs.
package tilelink_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [2:0]  a_size;
        logic [3:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        a_ready;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [2:0]  d_size;
        logic [3:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
    } tilelink_d;

endpackage

// File: rtl/tilelink_arbiter.sv
// Two-requester TileLink-UL arbiter with one outstanding transaction,
// round-robin on contention and a synthesized error response on timeout.
//
// Ports:
//   clock, reset_in       : clock, async active-high reset
//   req0_tla / req1_tla   : requester A channels (a_ready field ignored)
//   req0_ready/req1_ready : request accepted this cycle
//   req0_tld / req1_tld   : responses routed back to each requester
//   bus_tla / bus_tld     : shared downstream A and D channels
//   busy, owner           : transaction in flight and who holds the bus
//   timeout_count         : saturating count of synthesized error responses
module tilelink_arbiter
    import tilelink_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_in,
    input  tilelink_a   req0_tla,
    input  tilelink_a   req1_tla,
    output logic        req0_ready,
    output logic        req1_ready,
    output tilelink_d   req0_tld,
    output tilelink_d   req1_tld,
    output tilelink_a   bus_tla,
    input  tilelink_d   bus_tld,
    output logic        busy,
    output logic        owner,
    output logic [7:0]  timeout_count
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] OP_GET  = 3'd4;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [2:0]  op_q, op_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  src_q, src_d;
    logic [7:0]  tcnt_q, tcnt_d;

    logic        gnt;
    tilelink_a   gnt_a;
    tilelink_d   rsp;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        op_d       = op_q;
        size_d     = size_q;
        src_d      = src_q;
        tcnt_d     = tcnt_q;
        gnt        = 1'b0;
        gnt_a      = '0;
        rsp        = '0;
        bus_tla    = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        req0_tld   = '0;
        req1_tld   = '0;

        unique case (state_q)
            S_IDLE: begin
                // Reset gates the combinational grant so nothing is
                // accepted while reset_in is still high.
                if (!reset_in && (req0_tla.a_valid || req1_tla.a_valid)) begin
                    // On a tie the requester not granted last wins;
                    // otherwise whoever is valid wins.
                    if (req0_tla.a_valid && req1_tla.a_valid) begin
                        gnt = ~last_q;
                    end else begin
                        gnt = req1_tla.a_valid;
                    end
                    gnt_a         = gnt ? req1_tla : req0_tla;
                    bus_tla       = gnt_a;
                    bus_tla.a_valid = 1'b1;
                    req0_ready    = ~gnt;
                    req1_ready    = gnt;
                    last_d        = gnt;
                    owner_d       = gnt;
                    op_d          = gnt_a.a_opcode;
                    size_d        = gnt_a.a_size;
                    src_d         = gnt_a.a_source;
                    cnt_d         = '0;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real response beats the timeout even on its last cycle.
                if (bus_tld.d_valid) begin
                    rsp     = bus_tld;
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    rsp.d_valid  = 1'b1;
                    rsp.d_error  = 1'b1;
                    rsp.d_opcode = (op_q == OP_GET) ? 3'd1 : 3'd0;
                    rsp.d_size   = size_q;
                    rsp.d_source = src_q;
                    state_d      = S_IDLE;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (owner_q) begin
                    req1_tld = rsp;
                end else begin
                    req0_tld = rsp;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            // "Last granted" starts at 1 so requester 0 wins the first tie.
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= '0;
            size_q  <= '0;
            src_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            size_q  <= size_d;
            src_q   <= src_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign busy          = (state_q == S_WAIT);
    assign owner         = owner_q;
    assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_tilelink_arbiter.sv
// Scoreboard bench for tilelink_arbiter: a transaction-level model predicts
// grants and responses, a negedge monitor pops and compares them.
module tb_tilelink_arbiter;
    import tilelink_pkg::*;

    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset_in;
    tilelink_a  req0_tla, req1_tla, bus_tla;
    tilelink_d  req0_tld, req1_tld, bus_tld;
    logic       req0_ready, req1_ready, busy, owner;
    logic [7:0] timeout_count;

    tilelink_arbiter #(.TIMEOUT(TO)) dut (
        .clock         (clock),
        .reset_in      (reset_in),
        .req0_tla      (req0_tla),
        .req1_tla      (req1_tla),
        .req0_ready    (req0_ready),
        .req1_ready    (req1_ready),
        .req0_tld      (req0_tld),
        .req1_tld      (req1_tld),
        .bus_tla       (bus_tla),
        .bus_tld       (bus_tld),
        .busy          (busy),
        .owner         (owner),
        .timeout_count (timeout_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int        port;
        int        cyc;
        tilelink_a a;
    } exp_g_t;

    typedef struct {
        int        port;
        int        cyc;
        bit        full;
        tilelink_d d;
    } exp_d_t;

    exp_g_t    gq[$];
    exp_d_t    dq[$];
    int        n_chk = 0;
    int        n_fail = 0;
    bit        exp_busy = 1'b0;
    bit        exp_owner = 1'b0;
    int        exp_tc = 0;
    bit        pend[2];
    tilelink_a preq[2];
    bit        last = 1'b1;

    function automatic void chk(string name, logic [127:0] act,
                                logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     name, act, req, cyc);
        end
    endfunction

    function automatic tilelink_a rand_req();
        tilelink_a a;
        int ops[3] = '{0, 1, 4};
        a.a_valid   = 1'b1;
        a.a_opcode  = 3'(ops[$urandom_range(2)]);
        a.a_param   = 3'($urandom);
        a.a_size    = 3'($urandom_range(2));
        a.a_source  = 4'($urandom);
        a.a_address = $urandom;
        a.a_mask    = 4'($urandom);
        a.a_data    = $urandom;
        a.a_ready   = 1'($urandom);
        return a;
    endfunction

    function automatic tilelink_d rand_d();
        tilelink_d d;
        d.d_valid  = 1'b0;
        d.d_opcode = 3'($urandom_range(1));
        d.d_param  = 2'($urandom);
        d.d_size   = 3'($urandom);
        d.d_source = 4'($urandom);
        d.d_sink   = 1'($urandom);
        d.d_data   = $urandom;
        d.d_error  = 1'($urandom_range(9) == 0);
        return d;
    endfunction

    function automatic logic [127:0] err_view(tilelink_d d);
        return {d.d_valid, d.d_error, d.d_opcode,
                d.d_size, d.d_source, d.d_data};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_reqs();
        tilelink_a a0, a1;
        a0 = rand_req();
        a1 = rand_req();
        a0.a_valid = 1'b0;
        a1.a_valid = 1'b0;
        req0_tla = pend[0] ? preq[0] : a0;
        req1_tla = pend[1] ? preq[1] : a1;
    endtask

    task automatic new_req(int i);
        pend[i] = 1'b1;
        preq[i] = rand_req();
    endtask

    function automatic int pick();
        if (pend[0] && pend[1]) return last ? 0 : 1;
        return pend[1] ? 1 : 0;
    endfunction

    // Response arrives on WAIT cycle k; k >= TO means no response at all.
    task automatic run_txn(int k, int refill, tilelink_d r);
        int        g, c;
        tilelink_d e;
        drive_reqs();
        g = pick();
        c = cyc;
        gq.push_back('{g, c, preq[g]});
        r.d_valid = 1'b1;
        if (k < TO) begin
            dq.push_back('{g, c + k + 1, 1'b1, r});
        end else begin
            e          = '0;
            e.d_valid  = 1'b1;
            e.d_error  = 1'b1;
            e.d_opcode = (preq[g].a_opcode == 3'd4) ? 3'd1 : 3'd0;
            e.d_size   = preq[g].a_size;
            e.d_source = preq[g].a_source;
            dq.push_back('{g, c + TO, 1'b0, e});
        end
        tick();
        pend[g]   = 1'b0;
        last      = g[0];
        exp_busy  = 1'b1;
        exp_owner = g[0];
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(99) < refill) new_req(i);
        end
        drive_reqs();
        for (int i = 0; i < TO; i++) begin
            if (i > k) break;
            bus_tld = rand_d();
            if (i == k) bus_tld = r;
            tick();
        end
        exp_busy = 1'b0;
        bus_tld.d_valid = 1'b0;
        if (k >= TO) exp_tc = (exp_tc < 255) ? exp_tc + 1 : 255;
        chk("timeout_count", timeout_count, 128'(exp_tc));
    endtask

    task automatic idle_cycle(bit stray);
        drive_reqs();
        bus_tld = rand_d();
        bus_tld.d_valid = stray;
        tick();
        bus_tld.d_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_g_t    eg;
        exp_d_t    ed;
        tilelink_d act;
        chk("busy", busy, 128'(exp_busy));
        if (exp_busy) chk("owner", owner, 128'(exp_owner));
        chk("dual_ready", req0_ready & req1_ready, 0);
        chk("dual_d_valid", req0_tld.d_valid & req1_tld.d_valid, 0);
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_missed: got none want port %0d at cyc %0d",
                     gq[0].port, gq[0].cyc);
            void'(gq.pop_front());
        end
        while (dq.size() > 0 && dq[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_missed: got none want port %0d at cyc %0d",
                     dq[0].port, dq[0].cyc);
            void'(dq.pop_front());
        end
        if (req0_ready || req1_ready) begin
            if (gq.size() == 0) begin
                chk("grant_unexpected", {req1_ready, req0_ready}, 0);
            end else begin
                eg = gq.pop_front();
                chk("grant_port", req1_ready, 128'(eg.port));
                chk("grant_cyc", 128'(cyc), 128'(eg.cyc));
                chk("bus_tla", bus_tla, eg.a);
            end
        end else begin
            chk("bus_a_valid_idle", bus_tla.a_valid, 0);
        end
        if (req0_tld.d_valid || req1_tld.d_valid) begin
            act = req1_tld.d_valid ? req1_tld : req0_tld;
            if (dq.size() == 0) begin
                chk("rsp_unexpected",
                    {req1_tld.d_valid, req0_tld.d_valid}, 0);
            end else begin
                ed = dq.pop_front();
                chk("rsp_port", req1_tld.d_valid, 128'(ed.port));
                chk("rsp_cyc", 128'(cyc), 128'(ed.cyc));
                if (ed.full) chk("rsp_data", act, ed.d);
                else chk("rsp_err", err_view(act), err_view(ed.d));
            end
        end
    end

    initial begin
        tilelink_d r;
        pend[0]  = 1'b0;
        pend[1]  = 1'b0;
        bus_tld  = '0;
        reset_in = 1'b1;
        drive_reqs();
        req0_tla.a_valid = 1'b1;
        req1_tla.a_valid = 1'b1;
        repeat (3) tick();
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_a_valid", bus_tla.a_valid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_tc", timeout_count, 0);
        drive_reqs();
        reset_in = 1'b0;
        tick();

        // Single Get with a one-cycle response.
        new_req(0);
        preq[0].a_opcode  = 3'd4;
        preq[0].a_address = 32'h8000_0010;
        r = rand_d();
        r.d_opcode = 3'd1;
        r.d_error  = 1'b0;
        r.d_data   = 32'hDEAD_BEEF;
        run_txn(0, 0, r);

        // Contention: both requesters keep asking.
        new_req(0);
        new_req(1);
        repeat (8) run_txn(0, 100, rand_d());
        while (pend[0] || pend[1]) run_txn(0, 0, rand_d());

        // Timeout on a Get from requester 1.
        new_req(1);
        preq[1].a_opcode = 3'd4;
        run_txn(99, 0, rand_d());

        // Response on the last WAIT cycle wins over the timeout.
        new_req(0);
        run_txn(TO - 1, 0, rand_d());

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            if (!pend[0] && !pend[1]) begin
                idle_cycle(1'($urandom_range(1)));
                new_req($urandom_range(1));
                if ($urandom_range(2) == 0) new_req(0);
            end
            run_txn($urandom_range(0, TO + 4), 30, rand_d());
        end
        while (pend[0] || pend[1]) run_txn(0, 0, rand_d());

        // Repeated timeouts drive the counter into saturation.
        for (int n = 0; n < 300; n++) begin
            new_req($urandom_range(1));
            run_txn(99, 0, rand_d());
        end
        chk("tc_saturated", timeout_count, 255);

        // Reset three cycles after a grant drops the transaction.
        new_req(1);
        drive_reqs();
        gq.push_back('{1, cyc, preq[1]});
        tick();
        pend[1]   = 1'b0;
        exp_busy  = 1'b1;
        exp_owner = 1'b1;
        drive_reqs();
        tick();
        tick();
        reset_in = 1'b1;
        exp_busy = 1'b0;
        last     = 1'b1;
        exp_tc   = 0;
        req0_tla.a_valid = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", {req1_ready, req0_ready}, 0);
        chk("midrst_d_valid", {req1_tld.d_valid, req0_tld.d_valid}, 0);
        chk("midrst_tc", timeout_count, 0);
        tick();
        drive_reqs();
        reset_in = 1'b0;
        chk("midrst_owner", owner, 0);
        idle_cycle(1'b1);

        // Stray responses in IDLE with no requests.
        repeat (3) idle_cycle(1'b1);

        // After reset, requester 0 wins the first tie again.
        new_req(0);
        new_req(1);
        run_txn(1, 0, rand_d());
        run_txn(0, 0, rand_d());

        repeat (3) idle_cycle(1'b0);
        chk("grant_q_empty", 128'(gq.size()), 0);
        chk("rsp_q_empty", 128'(dq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
